// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_pkg
//  Description : Shared types, PS/2 command constants and parity helper for the
//                PS/2 host transmitter.
//  Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        RTS       = 3'd2,
        SHIFT     = 3'd3,
        ACK       = 3'd4,
        WAIT_IDLE = 3'd5
    } ps2_state_e;

    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_host_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_host_tx_if
//  Description : Command handshake and completion status of the PS/2 host
//                transmitter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ps2_host_tx_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       done;
    logic       ack_err;
    logic       timeout;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, done, ack_err, timeout
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, done, ack_err, timeout
    );

endinterface
`default_nettype wire

// File: rtl/ps2_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_sync_edge
//  Description : Two-flop synchronizer for an asynchronous PS/2 pin plus a
//                registered one-cycle falling-edge pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic pin_i,
    output logic level_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;
    logic fall_q;

    // Idle PS/2 lines are high; resetting to 1 avoids a false edge after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
            fall_q <= 1'b0;
        end else begin
            meta_q <= pin_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
            fall_q <= prev_q & ~sync_q;
        end
    end

    assign level_o = sync_q;
    assign fall_o  = fall_q;

endmodule
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_host_tx
//  Description : PS/2 host-to-device command transmitter (request-to-send,
//                10-bit frame shift, ACK check). Optional watchdog enabled
//                by defining PS2_TX_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int INHIBIT_US = 100,
    parameter int TIMEOUT_MS = 15
) (
    input  logic         clk,
    input  logic         rst,
    ps2_host_tx_if.slave bus,
    input  logic         ps2_clk_i,
    input  logic         ps2_data_i,
    output logic         ps2_clk_oe,
    output logic         ps2_data_oe
);

    localparam int INHIBIT_CYC = (CLK_HZ / 1_000_000) * INHIBIT_US;
    localparam int INH_W       = (INHIBIT_CYC > 1) ? $clog2(INHIBIT_CYC) : 1;
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYC - 1);

    logic clk_lvl;
    logic clk_fall;
    logic data_lvl;
    logic data_fall_unused;

    ps2_sync_edge u_sync_clk (
        .clk     (clk),
        .rst     (rst),
        .pin_i   (ps2_clk_i),
        .level_o (clk_lvl),
        .fall_o  (clk_fall)
    );

    ps2_sync_edge u_sync_data (
        .clk     (clk),
        .rst     (rst),
        .pin_i   (ps2_data_i),
        .level_o (data_lvl),
        .fall_o  (data_fall_unused)
    );

    ps2_state_e       state_q,   state_d;
    logic [9:0]       shreg_q,   shreg_d;
    logic [3:0]       bitcnt_q,  bitcnt_d;
    logic [INH_W-1:0] inh_q,     inh_d;
    logic             clk_oe_q,  clk_oe_d;
    logic             data_oe_q, data_oe_d;
    logic             ready_q,   ready_d;
    logic             done_q,    done_d;
    logic             ack_err_q, ack_err_d;
    logic             timeout_q, timeout_d;

`ifdef PS2_TX_TIMEOUT_EN
    localparam int TIMEOUT_CYC = (CLK_HZ / 1000) * TIMEOUT_MS;
    localparam int WD_W        = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    logic [WD_W-1:0] wd_q, wd_d;
`endif

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bitcnt_d  = bitcnt_q;
        inh_d     = inh_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        done_d    = 1'b0;
        ack_err_d = ack_err_q;
        timeout_d = timeout_q;
`ifdef PS2_TX_TIMEOUT_EN
        wd_d      = wd_q;
`endif

        case (state_q)
            IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                if (bus.tx_valid && ready_q) begin
                    state_d   = INHIBIT;
                    shreg_d   = {1'b1, odd_parity(bus.tx_data), bus.tx_data};
                    inh_d     = '0;
                    clk_oe_d  = 1'b1;
                    ack_err_d = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            INHIBIT: begin
                if (inh_q == INH_LAST) begin
                    state_d   = RTS;
                    data_oe_d = 1'b1;
                end else begin
                    inh_d = inh_q + 1'b1;
                end
            end
            RTS: begin
                // Data stays low as the start bit while the clock is handed back.
                state_d  = SHIFT;
                clk_oe_d = 1'b0;
                bitcnt_d = '0;
`ifdef PS2_TX_TIMEOUT_EN
                wd_d     = '0;
`endif
            end
            SHIFT: begin
                if (clk_fall) begin
                    data_oe_d = ~shreg_q[0];
                    shreg_d   = {1'b0, shreg_q[9:1]};
                    bitcnt_d  = bitcnt_q + 1'b1;
                    if (bitcnt_q == 4'd9) begin
                        state_d = ACK;
                    end
                end
            end
            ACK: begin
                if (clk_fall) begin
                    ack_err_d = data_lvl;
                    state_d   = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (clk_lvl && data_lvl) begin
                    done_d    = 1'b1;
                    timeout_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
            end
        endcase

`ifdef PS2_TX_TIMEOUT_EN
        // Watchdog overrides whatever the device phase was doing.
        if (state_q == SHIFT || state_q == ACK || state_q == WAIT_IDLE) begin
            wd_d = wd_q + 1'b1;
            if (wd_q == WD_LAST) begin
                state_d   = IDLE;
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                done_d    = 1'b1;
                timeout_d = 1'b1;
                ack_err_d = 1'b1;
            end
        end
`endif

        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bitcnt_q  <= '0;
            inh_q     <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            ready_q   <= 1'b0;
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bitcnt_q  <= bitcnt_d;
            inh_q     <= inh_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            ack_err_q <= ack_err_d;
            timeout_q <= timeout_d;
        end
    end

`ifdef PS2_TX_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`endif

    assign ps2_clk_oe   = clk_oe_q;
    assign ps2_data_oe  = data_oe_q;
    assign bus.tx_ready = ready_q;
    assign bus.done     = done_q;
    assign bus.ack_err  = ack_err_q;
    assign bus.timeout  = timeout_q;

endmodule
`default_nettype wire
